// File: rtl/sevenseg_scanner.sv
// Multiplexed seven-segment scanner: double-buffered digit codes with frame-aligned update
// handshake, per-digit blink, leading-zero suppression and 16-level PWM brightness.
module sevenseg_scanner #(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned REFRESH_DIV  = 75000,
  parameter int unsigned BLINK_FRAMES = 250,
  parameter bit          SIMULATE     = 1'b0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [5*NUM_DIGITS-1:0] d_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic [NUM_DIGITS-1:0]   blink_en_i,
  input  logic                    blank_lz_i,
  input  logic [3:0]              brightness_i,
  input  logic                    upd_req_i,
  output logic                    upd_ack_o,
  output logic [6:0]              seg_o,
  output logic                    dp_o,
  output logic [NUM_DIGITS-1:0]   an_o,
  output logic                    frame_done_o
);

  localparam int unsigned RefDiv      = SIMULATE ? 32'd4 : REFRESH_DIV;
  localparam int unsigned BlinkFrames = SIMULATE ? 32'd2 : BLINK_FRAMES;
  localparam int unsigned SlotW       = (RefDiv > 1) ? $clog2(RefDiv) : 1;
  localparam int unsigned IdxW        = $clog2(NUM_DIGITS);
  localparam int unsigned BlkW        = (BlinkFrames > 1) ? $clog2(BlinkFrames) : 1;
  localparam int unsigned CodeW       = 5 * NUM_DIGITS;

  localparam logic [SlotW-1:0] SlotMax   = SlotW'(RefDiv - 1);
  localparam logic [IdxW-1:0]  IdxMax    = IdxW'(NUM_DIGITS - 1);
  localparam logic [BlkW-1:0]  BlkMax    = BlkW'(BlinkFrames - 1);
  localparam logic [4:0]       CodeBlank = 5'h10;

  logic [SlotW-1:0]      slot_q, slot_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [3:0]            pwm_q;
  logic [BlkW-1:0]       blk_cnt_q, blk_cnt_d;
  logic                  blk_phase_q, blk_phase_d;
  logic                  pend_q, pend_d;
  logic [CodeW-1:0]      pend_code_q, pend_code_d, act_code_q, act_code_d;
  logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0] pend_blink_q, pend_blink_d, act_blink_q, act_blink_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  logic                  slot_wrap, frame_end, upd_ack;
  logic [NUM_DIGITS-1:0] lz_mask;
  logic                  lz_seen;
  logic [4:0]            cur_code;
  logic                  lit;

  function automatic logic [6:0] glyph(input logic [4:0] code);
    case (code)
      5'h00:   glyph = 7'b1000000;
      5'h01:   glyph = 7'b1111001;
      5'h02:   glyph = 7'b0100100;
      5'h03:   glyph = 7'b0110000;
      5'h04:   glyph = 7'b0011001;
      5'h05:   glyph = 7'b0010010;
      5'h06:   glyph = 7'b0000010;
      5'h07:   glyph = 7'b1111000;
      5'h08:   glyph = 7'b0000000;
      5'h09:   glyph = 7'b0010000;
      5'h0A:   glyph = 7'b0001000;
      5'h0B:   glyph = 7'b0000011;
      5'h0C:   glyph = 7'b1000110;
      5'h0D:   glyph = 7'b0100001;
      5'h0E:   glyph = 7'b0000110;
      5'h0F:   glyph = 7'b0001110;
      5'h11:   glyph = 7'b0111111;
      default: glyph = 7'b1111111;
    endcase
  endfunction

  assign slot_wrap = (slot_q == SlotMax);
  assign frame_end = slot_wrap && (idx_q == IdxMax);

  // Scan timing, blink phase and the pending/active buffer handshake.
  always_comb begin
    slot_d       = slot_wrap ? '0 : slot_q + 1'b1;
    idx_d        = idx_q;
    blk_cnt_d    = blk_cnt_q;
    blk_phase_d  = blk_phase_q;
    pend_d       = pend_q;
    pend_code_d  = pend_code_q;
    pend_dp_d    = pend_dp_q;
    pend_blink_d = pend_blink_q;
    act_code_d   = act_code_q;
    act_dp_d     = act_dp_q;
    act_blink_d  = act_blink_q;
    upd_ack      = 1'b0;

    if (slot_wrap) begin
      idx_d = (idx_q == IdxMax) ? '0 : idx_q + 1'b1;
    end

    if (frame_end) begin
      if (blk_cnt_q == BlkMax) begin
        blk_cnt_d   = '0;
        blk_phase_d = ~blk_phase_q;
      end else begin
        blk_cnt_d = blk_cnt_q + 1'b1;
      end
      // A request landing on the boundary bypasses the pending buffer.
      if (upd_req_i) begin
        act_code_d  = d_i;
        act_dp_d    = dp_i;
        act_blink_d = blink_en_i;
        upd_ack     = 1'b1;
      end else if (pend_q) begin
        act_code_d  = pend_code_q;
        act_dp_d    = pend_dp_q;
        act_blink_d = pend_blink_q;
        upd_ack     = 1'b1;
      end
      pend_d = 1'b0;
    end else if (upd_req_i) begin
      pend_code_d  = d_i;
      pend_dp_d    = dp_i;
      pend_blink_d = blink_en_i;
      pend_d       = 1'b1;
    end
  end

  // Zeros above the most significant non-zero code are blanked; digit 0 always shows.
  always_comb begin
    lz_mask = '0;
    lz_seen = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (act_code_q[5*i +: 5] != 5'h00) begin
        lz_seen = 1'b1;
      end else if (!lz_seen) begin
        lz_mask[i] = 1'b1;
      end
    end
  end

  always_comb begin
    cur_code = act_code_q[5*int'(idx_q) +: 5];
    if (blank_lz_i && lz_mask[idx_q]) begin
      cur_code = CodeBlank;
    end
    lit  = (pwm_q <= brightness_i) && !(blk_phase_q && act_blink_q[idx_q]);
    an_d = '1;
    if (lit) begin
      an_d[idx_q] = 1'b0;
    end
    seg_d = glyph(cur_code);
    dp_d  = ~act_dp_q[idx_q];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slot_q       <= '0;
      idx_q        <= '0;
      pwm_q        <= '0;
      blk_cnt_q    <= '0;
      blk_phase_q  <= 1'b0;
      pend_q       <= 1'b0;
      pend_code_q  <= {NUM_DIGITS{CodeBlank}};
      pend_dp_q    <= '0;
      pend_blink_q <= '0;
      act_code_q   <= {NUM_DIGITS{CodeBlank}};
      act_dp_q     <= '0;
      act_blink_q  <= '0;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      an_q         <= '1;
    end else begin
      slot_q       <= slot_d;
      idx_q        <= idx_d;
      pwm_q        <= pwm_q + 4'd1;
      blk_cnt_q    <= blk_cnt_d;
      blk_phase_q  <= blk_phase_d;
      pend_q       <= pend_d;
      pend_code_q  <= pend_code_d;
      pend_dp_q    <= pend_dp_d;
      pend_blink_q <= pend_blink_d;
      act_code_q   <= act_code_d;
      act_dp_q     <= act_dp_d;
      act_blink_q  <= act_blink_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
    end
  end

  assign seg_o        = seg_q;
  assign dp_o         = dp_q;
  assign an_o         = an_q;
  assign upd_ack_o    = upd_ack;
  assign frame_done_o = frame_end;

endmodule

// File: tb/tb_sevenseg_scanner.sv
// Scoreboard bench for sevenseg_scanner (8 digits, SIMULATE=1: 4 clks/slot, 32 clks/frame).
module tb_sevenseg_scanner;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b1;
  logic [39:0] d_i = {8{5'h10}};
  logic [7:0]  dp_i = '0;
  logic [7:0]  blink_en_i = '0;
  logic        blank_lz_i = 1'b0;
  logic [3:0]  brightness_i = 4'd15;
  logic        upd_req_i = 1'b0;
  logic        upd_ack_o;
  logic [6:0]  seg_o;
  logic        dp_o;
  logic [7:0]  an_o;
  logic        frame_done_o;

  always #5 clk = ~clk;

  sevenseg_scanner #(
    .NUM_DIGITS  (8),
    .REFRESH_DIV (75000),
    .BLINK_FRAMES(250),
    .SIMULATE    (1'b1)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .d_i         (d_i),
    .dp_i        (dp_i),
    .blink_en_i  (blink_en_i),
    .blank_lz_i  (blank_lz_i),
    .brightness_i(brightness_i),
    .upd_req_i   (upd_req_i),
    .upd_ack_o   (upd_ack_o),
    .seg_o       (seg_o),
    .dp_o        (dp_o),
    .an_o        (an_o),
    .frame_done_o(frame_done_o)
  );

  typedef struct {
    int         cyc;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
  } exp_t;

  exp_t exp_q[$];
  int   ack_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  // Clock edges since reset release; cycle c shows the scan state of cycle c-1.
  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      checks++;
      failures++;
      $display("FAIL disp_missed cyc=%0d expected at cyc=%0d", cyc, e.cyc);
    end
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      e = exp_q.pop_front();
      checks++;
      if (an_o !== e.an || seg_o !== e.seg || dp_o !== e.dp || frame_done_o !== e.fd) begin
        failures++;
        $display("FAIL disp@%0d got an=%h seg=%h dp=%b fd=%b, want an=%h seg=%h dp=%b fd=%b",
                 cyc, an_o, seg_o, dp_o, frame_done_o, e.an, e.seg, e.dp, e.fd);
      end
    end
    while (ack_q.size() > 0 && ack_q[0] < cyc) begin
      checks++;
      failures++;
      $display("FAIL ack_missed cyc=%0d wanted ack at cyc=%0d", cyc, ack_q.pop_front());
    end
    if (upd_ack_o === 1'b1) begin
      checks++;
      if (ack_q.size() == 0) begin
        failures++;
        $display("FAIL ack_unexpected got ack at cyc=%0d, want none", cyc);
      end else if (ack_q[0] != cyc) begin
        failures++;
        $display("FAIL ack_time got ack at cyc=%0d, want cyc=%0d", cyc, ack_q[0]);
      end else begin
        void'(ack_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int c);
    int guard = 0;
    while (cyc < c && guard < 5000) begin
      tick();
      guard++;
    end
  endtask

  task automatic exp_disp(input int c, input logic [7:0] an, input logic [6:0] seg,
                          input logic dp, input logic fd);
    exp_t e;
    e.cyc = c; e.an = an; e.seg = seg; e.dp = dp; e.fd = fd;
    exp_q.push_back(e);
  endtask

  task automatic pulse_req();
    upd_req_i = 1'b1;
    tick();
    upd_req_i = 1'b0;
  endtask

  // Reset output state is checked at the first falling edge after assertion.
  task automatic do_reset();
    exp_disp(0, 8'hFF, 7'h7F, 1'b1, 1'b0);
    rst_ni = 1'b0;
    tick(); tick(); tick();
    rst_ni = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Blank codes, full brightness, no update: anodes walk, frame_done every 32 clks.
    #1;
    do_reset();
    exp_disp(1,  8'hFE, 7'h7F, 1'b1, 1'b0);
    exp_disp(5,  8'hFD, 7'h7F, 1'b1, 1'b0);
    exp_disp(29, 8'h7F, 7'h7F, 1'b1, 1'b0);
    exp_disp(30, 8'h7F, 7'h7F, 1'b1, 1'b0);
    exp_disp(31, 8'h7F, 7'h7F, 1'b1, 1'b1);
    exp_disp(32, 8'h7F, 7'h7F, 1'b1, 1'b0);
    exp_disp(33, 8'hFE, 7'h7F, 1'b1, 1'b0);
    exp_disp(63, 8'h7F, 7'h7F, 1'b1, 1'b1);

    // Codes 0..7, dp on digit 0: ack at boundary 95, new data from cycle 97.
    goto(70);
    d_i  = {5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'd0};
    dp_i = 8'h01;
    ack_q.push_back(95);
    exp_disp(95,  8'h7F, 7'h7F, 1'b1, 1'b1);
    exp_disp(96,  8'h7F, 7'h7F, 1'b1, 1'b0);
    exp_disp(97,  8'hFE, 7'h40, 1'b0, 1'b0);
    exp_disp(101, 8'hFD, 7'h79, 1'b1, 1'b0);
    exp_disp(125, 8'h7F, 7'h78, 1'b1, 1'b0);
    exp_disp(127, 8'h7F, 7'h78, 1'b1, 1'b1);
    pulse_req();

    // Two requests in one frame: last wins, single ack at 159.
    goto(130);
    d_i  = {8{5'h08}};
    dp_i = 8'h00;
    ack_q.push_back(159);
    exp_disp(160, 8'h7F, 7'h78, 1'b1, 1'b0);
    exp_disp(161, 8'hFE, 7'h0E, 1'b1, 1'b0);
    exp_disp(165, 8'hFD, 7'h0E, 1'b1, 1'b0);
    exp_disp(189, 8'h7F, 7'h0E, 1'b1, 1'b0);
    pulse_req();
    goto(140);
    d_i = {8{5'h0F}};
    pulse_req();

    // Leading-zero suppression, digit 2 = 1.
    goto(170);
    blank_lz_i = 1'b1;
    d_i = {5'h0, 5'h0, 5'h0, 5'h0, 5'h0, 5'h1, 5'h0, 5'h0};
    ack_q.push_back(191);
    exp_disp(193, 8'hFE, 7'h40, 1'b1, 1'b0);
    exp_disp(197, 8'hFD, 7'h40, 1'b1, 1'b0);
    exp_disp(201, 8'hFB, 7'h79, 1'b1, 1'b0);
    exp_disp(205, 8'hF7, 7'h7F, 1'b1, 1'b0);
    exp_disp(213, 8'hDF, 7'h7F, 1'b1, 1'b0);
    exp_disp(221, 8'h7F, 7'h7F, 1'b1, 1'b0);
    pulse_req();

    // All zeros: only digit 0 shows.
    goto(230);
    d_i = {8{5'h00}};
    ack_q.push_back(255);
    exp_disp(257, 8'hFE, 7'h40, 1'b1, 1'b0);
    exp_disp(261, 8'hFD, 7'h7F, 1'b1, 1'b0);
    exp_disp(285, 8'h7F, 7'h7F, 1'b1, 1'b0);
    pulse_req();

    // blank_lz is live, not buffered.
    goto(290);
    exp_disp(294, 8'hFD, 7'h40, 1'b1, 1'b0);
    blank_lz_i = 1'b0;

    // brightness=3: lit for pwm 0..3 only; brightness=0: pwm 0 only.
    goto(300);
    brightness_i = 4'd3;
    exp_disp(321, 8'hFE, 7'h40, 1'b1, 1'b0);
    exp_disp(324, 8'hFE, 7'h40, 1'b1, 1'b0);
    exp_disp(325, 8'hFF, 7'h40, 1'b1, 1'b0);
    exp_disp(330, 8'hFF, 7'h40, 1'b1, 1'b0);
    exp_disp(336, 8'hFF, 7'h40, 1'b1, 1'b0);
    exp_disp(337, 8'hEF, 7'h40, 1'b1, 1'b0);
    goto(340);
    brightness_i = 4'd0;
    exp_disp(353, 8'hFE, 7'h40, 1'b1, 1'b0);
    exp_disp(354, 8'hFF, 7'h40, 1'b1, 1'b0);
    exp_disp(369, 8'hEF, 7'h40, 1'b1, 1'b0);
    exp_disp(370, 8'hFF, 7'h40, 1'b1, 1'b0);
    goto(372);
    brightness_i = 4'd15;
    goto(380);

    // Blink on digit 7: blanked during frames 2-3 and 6-7 after reset.
    do_reset();
    goto(2);
    d_i        = {8{5'h08}};
    blink_en_i = 8'h80;
    ack_q.push_back(31);
    exp_disp(61,  8'h7F, 7'h00, 1'b1, 1'b0);
    exp_disp(65,  8'hFE, 7'h00, 1'b1, 1'b0);
    exp_disp(93,  8'hFF, 7'h00, 1'b1, 1'b0);
    exp_disp(96,  8'hFF, 7'h00, 1'b1, 1'b0);
    exp_disp(97,  8'hFE, 7'h00, 1'b1, 1'b0);
    exp_disp(125, 8'hFF, 7'h00, 1'b1, 1'b0);
    exp_disp(157, 8'h7F, 7'h00, 1'b1, 1'b0);
    exp_disp(221, 8'hFF, 7'h00, 1'b1, 1'b0);
    pulse_req();

    // Mid-frame reset with a pending update: update discarded, no ack.
    goto(230);
    d_i = {8{5'h01}};
    pulse_req();
    goto(240);
    do_reset();
    exp_disp(1,  8'hFE, 7'h7F, 1'b1, 1'b0);
    exp_disp(33, 8'hFE, 7'h7F, 1'b1, 1'b0);
    exp_disp(61, 8'h7F, 7'h7F, 1'b1, 1'b0);
    goto(70);

    checks++;
    if (exp_q.size() != 0 || ack_q.size() != 0) begin
      failures++;
      $display("FAIL drain got %0d disp / %0d ack left, want 0 / 0", exp_q.size(), ack_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sevenseg_scanner.md
Name: sevenseg_scanner

Overview:
Parametrised successor to the board's eight-digit seven-segment driver. It time-multiplexes NUM_DIGITS display digits and adds double-buffered updates with a request/acknowledge handshake, per-digit blink, leading-zero suppression and 16-level PWM brightness. It sits between the PicoBlaze interface, which supplies digit codes, and the an/seg/dp board pins, running on sysclk.

Parameters:
NUM_DIGITS, 8, number of multiplexed digits (2..16)
REFRESH_DIV, 75000, clk cycles per digit slot (1 ms at 75 MHz)
BLINK_FRAMES, 250, full scan frames per blink half-period
SIMULATE, 0, 1 forces REFRESH_DIV=4 and BLINK_FRAMES=2

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  asynchronous, active-low reset
d_in  in  5*NUM_DIGITS  digit codes; digit i at [5i+4:5i]
dp_in  in  NUM_DIGITS  decimal points, 1 = lit
blink_en  in  NUM_DIGITS  1 = digit blinks
blank_lz  in  1  1 = suppress leading zeros
brightness  in  4  0 = 1/16 duty, 15 = full duty
upd_req  in  1  one-cycle pulse; capture d_in/dp_in/blink_en into the pending buffer
upd_ack  out  1  one-cycle pulse when pending data becomes active
seg  out  7  cathodes, active-low, seg[0]=a .. seg[6]=g
dp  out  1  decimal point cathode, active-low
an  out  NUM_DIGITS  anodes, active-low, one-hot or all off
frame_done  out  1  one-cycle pulse at end of each full scan

Behaviour:
- Reset (reset=0, asynchronous):
  - an all 1, seg=7'h7F, dp=1, upd_ack=0, frame_done=0.
  - Active and pending codes = 0x10 (blank). Active dp_in and blink_en = 0.
  - Slot counter, digit index, PWM counter, blink counter and blink phase = 0. Pending flag = 0.
- Slot counter counts 0..REFRESH_DIV-1. On wrap, the digit index increments modulo NUM_DIGITS.
- Frame boundary: the cycle in which the index wraps from NUM_DIGITS-1 to 0. frame_done=1 for exactly that cycle.
- Code decode:
  - 0x00-0x0F: hex glyphs. Examples: 0 -> 7'b1000000, 8 -> 7'b0000000, F -> 7'b0001110.
  - 0x10: blank. 0x11: '-' (7'b0111111).
  - 0x12-0x1F: blank.
- Leading-zero suppression (blank_lz=1): scanning from digit NUM_DIGITS-1 downward, each digit with code 0x00 that precedes the first non-zero code decodes as blank. Digit 0 is never suppressed. dp still follows dp_in.
- PWM: a free-running 4-bit counter increments every clk. The selected anode is driven low only while pwm_cnt <= brightness; otherwise an is all 1.
- Blink: the blink counter counts frame boundaries and toggles blink_phase every BLINK_FRAMES frames. While blink_phase=1, any digit with active blink_en=1 has its anode forced high.
- Outputs are registered: seg, dp and an reflect the index/PWM state of the previous cycle (1-cycle latency). an is never multi-hot.
- Update handshake:
  - upd_req captures the inputs into the pending buffer and sets the pending flag.
  - At the next frame boundary, pending is copied to active, the flag clears, and upd_ack pulses 1 cycle.
  - Multiple upd_req before a boundary: last one wins, single upd_ack.
  - upd_req in the boundary cycle itself: inputs load directly into active and upd_ack pulses that cycle.
  - No upd_req: active data is retained indefinitely and upd_ack stays 0.
- blank_lz and brightness are not buffered; they take effect on the next cycle.
- Reset asserted mid-frame: all state returns to reset values immediately and any pending update is discarded (no upd_ack).

Test Plan:
- Reset, then SIMULATE=1, NUM_DIGITS=8, no upd_req -> an cycles 8'hFE, FD, ... 7F, every 4 clks. seg=7'h7F throughout. frame_done pulses every 32 clks.
- upd_req with d_in = codes 0..7, dp_in=8'h01, brightness=15 -> upd_ack exactly at the next frame boundary. Next frame: digit 0 seg=7'b1000000 with dp=0; digit 7 seg=7'b1111000.
- Two upd_req in one frame (0x08 everywhere, then 0x0F everywhere) -> one upd_ack; all digits show 7'b0001110.
- blank_lz=1, codes {0,0,0,0,0,1,0,0} (digit7..digit0) -> digits 7-3 seg=7'h7F; digits 2,1,0 show '1', '0', '0'. All-zero codes -> only digit 0 shows '0'.
- brightness=3 -> the active anode is low for 4 of every 16 clks. brightness=0 -> 1 of 16.
- blink_en=8'h80, BLINK_FRAMES=2 -> an[7] stays high during frames 2-3, 6-7, ...; the other digits are unaffected. Assert reset mid-frame with a pending update -> outputs return to reset values and no upd_ack follows.
